// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit memory bus between instruction fetch and data requesters.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  // Fetch requester
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // Data requester
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  // Memory bus
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_be_o,
  input  logic        m_ready_i,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e state_q, state_d;
  owner_e owner_q;
  logic   fetch_forced;
  logic   pick_data;
  logic   accept;
  logic   respond;

  assign accept  = (state_q == ADDR) && m_ready_i;
  assign respond = (state_q == DATA) && m_rvalid_i;

  assign m_req_o  = (state_q == ADDR);
  assign if_gnt_o = accept && (owner_q == OWN_FETCH);
  assign d_gnt_o  = accept && (owner_q == OWN_DATA);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;

  // Number of data grants issued while a fetch was left waiting; saturates.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      starve_cnt_q <= '0;
    end else if (if_gnt_o) begin
      starve_cnt_q <= '0;
    end else if (d_gnt_o && if_req_i && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end

  assign fetch_forced = if_req_i && (starve_cnt_q == CNT_MAX);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign fetch_forced        = 1'b0;
`endif

  assign pick_data = d_req_i && !fetch_forced;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req_i || d_req_i) state_d = ADDR;
      ADDR:    if (m_ready_i)           state_d = DATA;
      DATA:    if (m_rvalid_i)          state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Transaction fields are captured once at arbitration and held until the next one.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      owner_q     <= OWN_FETCH;
      m_we_o      <= 1'b0;
      m_addr_o    <= '0;
      m_wdata_o   <= '0;
      m_be_o      <= '0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      if ((state_q == IDLE) && (if_req_i || d_req_i)) begin
        if (pick_data) begin
          owner_q   <= OWN_DATA;
          m_we_o    <= d_we_i;
          m_addr_o  <= d_addr_i;
          m_wdata_o <= d_wdata_i;
          m_be_o    <= d_be_i;
        end else begin
          owner_q   <= OWN_FETCH;
          m_we_o    <= 1'b0;
          m_addr_o  <= if_addr_i;
          m_wdata_o <= '0;
          m_be_o    <= 4'hF;
        end
      end

      if_rvalid_o <= respond && (owner_q == OWN_FETCH);
      d_rvalid_o  <= respond && (owner_q == OWN_DATA);

      if (respond && (owner_q == OWN_FETCH)) if_rdata_o <= m_rdata_i;
      // Store acks complete the transaction but carry no data for the requester.
      if (respond && (owner_q == OWN_DATA) && !m_we_o) d_rdata_o <= m_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model of requesters, priority/starvation rules and response routing.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [3:0]  d_be_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;
  logic        m_ready_i = 1'b0;
  logic        m_rvalid_i = 1'b0;
  logic [31:0] m_rdata_i = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_ready_i(m_ready_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          if_pend = 1'b0;
  bit          d_pend = 1'b0;
  int          streak = 0;
  int          req_mode = 0;   // 0: directed, 1: random arrivals, 2: both always requesting
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  int          obs_if_gnts = 0;
  int          obs_d_gnts = 0;
  int          exp_fetch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pick_data();
`ifdef ARB_STARVE_GUARD_EN
    if (if_pend && (streak >= int'(STARVE_LIMIT))) return 1'b0;
`endif
    return d_pend;
  endfunction

  task automatic new_requests();
    if (req_mode == 0) return;
    if (!if_pend && (req_mode == 2 || $urandom_range(0, 2) == 0)) begin
      if_pend   = 1'b1;
      if_req_i  = 1'b1;
      if_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_pend && (req_mode == 2 || $urandom_range(0, 1) == 0)) begin
      d_pend    = 1'b1;
      d_req_i   = 1'b1;
      d_we_i    = 1'($urandom_range(0, 1));
      d_addr_i  = $urandom & 32'hFFFF_FFFC;
      d_wdata_i = $urandom;
      d_be_i    = 4'($urandom);
    end
  endtask

  // Entered at the negedge of an IDLE cycle with requests already presented;
  // leaves at the negedge of the cycle in which the response pulse is visible.
  task automatic run_txn(input int rdy_wait, input int rv_wait, input logic [31:0] rd);
    bit          own_d;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    own_d = model_pick_data();
    if (own_d) begin
      e_we = d_we_i; e_addr = d_addr_i; e_wdata = d_wdata_i; e_be = d_be_i;
    end else begin
      e_we = 1'b0; e_addr = if_addr_i; e_wdata = '0; e_be = 4'hF;
    end
    @(posedge clk); #1;
    for (int i = 0; i <= rdy_wait; i++) begin
      m_ready_i  = (i == rdy_wait);
      m_rvalid_i = 1'($urandom_range(0, 1));
      m_rdata_i  = $urandom;
      @(negedge clk);
      check("addr_m_req", m_req_o, 1'b1);
      check("addr_m_we", m_we_o, e_we);
      check("addr_m_addr", m_addr_o, e_addr);
      check("addr_m_wdata", m_wdata_o, e_wdata);
      check("addr_m_be", m_be_o, e_be);
      check("addr_if_gnt", if_gnt_o, !own_d && (i == rdy_wait));
      check("addr_d_gnt", d_gnt_o, own_d && (i == rdy_wait));
      check("addr_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
      if (i == rdy_wait) begin
        if (if_gnt_o) obs_if_gnts++;
        if (d_gnt_o)  obs_d_gnts++;
      end else if ($urandom_range(0, 3) == 0) begin
        // Owner withdraws early; the latched transaction must still finish.
        if (own_d) begin d_req_i = 1'b0; d_pend = 1'b0; end
        else       begin if_req_i = 1'b0; if_pend = 1'b0; end
      end
      @(posedge clk); #1;
    end
    m_ready_i = 1'b0;
    if (own_d) begin
      if (if_pend && streak < int'(STARVE_LIMIT)) streak++;
      d_req_i = 1'b0; d_pend = 1'b0;
    end else begin
      streak = 0;
      if_req_i = 1'b0; if_pend = 1'b0;
    end
    for (int i = 0; i <= rv_wait; i++) begin
      m_rvalid_i = (i == rv_wait);
      m_rdata_i  = (i == rv_wait) ? rd : $urandom;
      m_ready_i  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("data_m_req", m_req_o, 1'b0);
      check("data_gnts", {if_gnt_o, d_gnt_o}, 2'b00);
      check("data_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
      check("data_m_addr", m_addr_o, e_addr);
      @(posedge clk); #1;
    end
    m_rvalid_i = 1'b0;
    m_ready_i  = 1'b0;
    if (!own_d)     exp_if_rdata = rd;
    else if (!e_we) exp_d_rdata  = rd;
    new_requests();
    @(negedge clk);
    check("resp_if_rvalid", if_rvalid_o, !own_d);
    check("resp_d_rvalid", d_rvalid_o, own_d);
    check("resp_if_rdata", if_rdata_o, exp_if_rdata);
    check("resp_d_rdata", d_rdata_o, exp_d_rdata);
    check("resp_m_req", m_req_o, 1'b0);
  endtask

  // One IDLE cycle with nothing pending, optionally with a stray response from memory.
  task automatic idle_cycle(input bit spur);
    m_rvalid_i = spur;
    m_rdata_i  = $urandom;
    m_ready_i  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
    m_ready_i  = 1'b0;
    new_requests();
    @(negedge clk);
    check("idle_m_req", m_req_o, 1'b0);
    check("idle_gnts", {if_gnt_o, d_gnt_o}, 2'b00);
    check("idle_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
    check("idle_if_rdata", if_rdata_o, exp_if_rdata);
    check("idle_d_rdata", d_rdata_o, exp_d_rdata);
  endtask

  initial begin
    // Reset state
    #2 reset_i = 1'b0;
    #20;
    check("rst_m_req", m_req_o, 1'b0);
    check("rst_gnts", {if_gnt_o, d_gnt_o}, 2'b00);
    check("rst_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
    check("rst_m_we", m_we_o, 1'b0);
    check("rst_m_addr", m_addr_o, 32'h0);
    check("rst_m_wdata", m_wdata_o, 32'h0);
    check("rst_m_be", m_be_o, 4'h0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    @(negedge clk);
    reset_i = 1'b1;

    // Single zero-wait load
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0100; d_wdata_i = '0; d_be_i = 4'hF;
    d_pend = 1'b1;
    run_txn(0, 0, 32'hDEAD_BEEF);
    idle_cycle(1'b0);

    // Simultaneous fetch and store: store first, then fetch
    if_req_i = 1'b1; if_addr_i = 32'h0000_0000; if_pend = 1'b1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0200;
    d_wdata_i = 32'h1234_5678; d_be_i = 4'b0011; d_pend = 1'b1;
    run_txn(0, 0, $urandom);
    run_txn(0, 0, $urandom);

    // Stretched address and data phases
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0404; d_be_i = 4'hF; d_pend = 1'b1;
    run_txn(3, 2, 32'hA5A5_0F0F);

    // Spurious response while idle
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset asserted during the data phase, late response afterwards
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0300; d_be_i = 4'hF; d_wdata_i = '0;
    @(posedge clk); #1; m_ready_i = 1'b1;
    @(posedge clk); #1; m_ready_i = 1'b0; d_req_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    check("mid_rst_m_req", m_req_o, 1'b0);
    check("mid_rst_m_addr", m_addr_o, 32'h0);
    check("mid_rst_m_be", m_be_o, 4'h0);
    check("mid_rst_d_rdata", d_rdata_o, 32'h0);
    check("mid_rst_if_rdata", if_rdata_o, 32'h0);
    check("mid_rst_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
    @(negedge clk);
    reset_i = 1'b1;
    m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
    @(negedge clk);
    check("late_rvalids", {if_rvalid_o, d_rvalid_o}, 2'b00);
    check("late_d_rdata", d_rdata_o, 32'h0);
    check("late_m_req", m_req_o, 1'b0);
    exp_if_rdata = '0; exp_d_rdata = '0; streak = 0; if_pend = 1'b0; d_pend = 1'b0;

    // Both requesters continuously asking: starvation guard behaviour
    req_mode = 2;
    obs_if_gnts = 0; obs_d_gnts = 0;
    new_requests();
    for (int t = 0; t < 10; t++) run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
`ifdef ARB_STARVE_GUARD_EN
    exp_fetch = 2;
`else
    exp_fetch = 0;
`endif
    check("guard_fetch_grants", obs_if_gnts, exp_fetch);
    check("guard_data_grants", obs_d_gnts, 10 - exp_fetch);
    if_req_i = 1'b0; if_pend = 1'b0; d_req_i = 1'b0; d_pend = 1'b0;

    // Randomized traffic
    req_mode = 1;
    for (int t = 0; t < 150; t++) begin
      if (if_pend || d_pend) run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      else                   idle_cycle(1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port 32-bit memory bus between the instruction-fetch requester (stage1) and the data requester (mem_stage) of the 5-stage RISC-V core. It arbitrates, sequences one outstanding transaction at a time through a request/accept/response handshake, and routes each response back to its owner. Data wins by default; a starvation guard can force fetch through.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced (starvation guard only).
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  32  fetch byte address.
- if_gnt_o  out  1  one-cycle pulse: fetch accepted by memory.
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  32  fetched word.
- d_req_i  in  1  data request; held with all d_* fields until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  store data.
- d_be_i  in  4  store byte enables.
- d_gnt_o  out  1  one-cycle pulse: data accepted.
- d_rvalid_o  out  1  one-cycle pulse: load data valid / store complete.
- d_rdata_o  out  32  load word.
- m_req_o  out  1  bus request.
- m_we_o, m_addr_o, m_wdata_o, m_be_o  out  1/32/32/4  latched transaction fields.
- m_ready_i  in  1  memory accepts when m_req_o && m_ready_i.
- m_rvalid_i  in  1  response/ack for the accepted transaction (reads and writes).
- m_rdata_i  in  32  read data, valid with m_rvalid_i.

## Operation
- States: IDLE, ADDR, DATA. Owner register: FETCH or DATA.
- IDLE: if any request, pick owner, latch its fields into m_* registers, go ADDR. Nothing requested: stay.
- Priority: d_req_i over if_req_i; with guard, fetch wins when starve_cnt == STARVE_LIMIT and if_req_i high.
- ADDR: m_req_o = 1, fields stable. On m_ready_i: owner gnt_o pulses this cycle, go DATA.
- DATA: m_req_o = 0. On m_rvalid_i: register m_rdata_i into owner rdata_o, set owner rvalid_o next cycle, go IDLE.
- Stores: d_rvalid_o pulses as completion; d_rdata_o unchanged.
- m_we_o/m_wdata_o/m_be_o forced 0 for fetch transactions (m_be_o = 4'hF on fetch).
- m_rvalid_i in IDLE or ADDR is ignored.
- rdata_o registers hold last value until next response to that owner.
- Requester dropping req before gnt: transaction already latched still completes; response still delivered.

## Timing
- Reset (async, active-low) values: state IDLE, owner FETCH, all gnt/rvalid/m_req_o 0, m_* fields 0, rdata_o 0, starve_cnt 0. Reset mid-transaction drops it; late m_rvalid_i ignored.
- Zero-wait memory: req sampled edge 0 → m_req_o and gnt_o in cycle 1 → m_rvalid_i cycle 2 → rvalid_o cycle 3.
- rvalid_o cycle coincides with IDLE; a new arbitration can be sampled at that edge: throughput one transaction per 3 cycles.
- m_ready_i low stretches ADDR; m_rvalid_i low stretches DATA; no timeout.
- Both requests same IDLE cycle: data granted, fetch waits; its req must stay high.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve_cnt (width clog2(STARVE_LIMIT+1)) increments on each data grant while if_req_i high, saturates at STARVE_LIMIT, clears on fetch grant; at limit, fetch wins next arbitration.
- Undefined: strict data priority, no counter; STARVE_LIMIT unused.

## Test plan
- Single load, d_addr_i 0x100, memory zero-wait returning 0xDEADBEEF -> d_gnt_o cycle 1, d_rvalid_o cycle 3, d_rdata_o 0xDEADBEEF, if_rvalid_o never set.
- Simultaneous if_req_i (0x0) and d_req_i store (0x200, 0x12345678, be 4'b0011) -> store issued first with m_be_o 4'b0011, fetch issued next with m_we_o 0, m_be_o 4'hF.
- m_ready_i low 3 cycles, then m_rvalid_i delayed 2 cycles -> m_* fields stable throughout, exactly one gnt and one rvalid pulse.
- Guard on, STARVE_LIMIT 4, d_req_i and if_req_i both held high -> 4 data grants then 1 fetch grant, repeating; guard off -> fetch never granted.
- reset_i low during DATA, m_rvalid_i arrives after release -> no rvalid_o, state IDLE, all outputs at reset values.
- Spurious m_rvalid_i while IDLE -> no rvalid_o, rdata_o unchanged.
